ccff_chain_loader: RTL and testbench

- Configuration-chain programmer driving the `ccff_head` end of a tile's configuration flip-flop chain, and reading back the old contents from the `ccff_tail` end.
- Accepts bitstream words over a valid/ready handshake and serialises them LSB-first into the chain, CHAIN_LENGTH bits per load.
- Bits emerging from `ccff_tail` during the load are reassembled into readback words, so software can verify or save the previous configuration.
- Sits between the bitstream source and the fabric's chain; clocked by the programming clock.

---
 rtl/ccff_chain_loader.sv | 96 +++++++++
 tb/tb_ccff_chain_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: loads a config chain LSB-first from bs_data/bs_valid/bs_ready via ccff_head/ccff_shift_en, rebuilds old contents from ccff_tail into rb_data/rb_valid, start/busy/done frame each load
module ccff_chain_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] bs_data,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int RW = $clog2(CHAIN_LENGTH + 1);
  localparam int CW = $clog2(WORD_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t state;
  logic [RW-1:0] remaining;
  logic [CW-1:0] bit_cnt, rb_idx;
  logic [WORD_WIDTH-1:0] sr, rb_buf, rb_next;
  logic last_bit, last_chain, rb_full;
  always_comb begin
    rb_next = rb_buf | (WORD_WIDTH'(ccff_tail) << rb_idx);
    last_bit = bit_cnt == CW'(1);
    last_chain = remaining == RW'(1);
    rb_full = rb_idx == CW'(WORD_WIDTH - 1);
  end
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
      remaining <= '0;
      bit_cnt <= '0;
      rb_idx <= '0;
      sr <= '0;
      rb_buf <= '0;
      bs_ready <= 1'b0;
      ccff_head <= 1'b0;
      ccff_shift_en <= 1'b0;
      rb_data <= '0;
      rb_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          busy <= 1'b1;
          bs_ready <= 1'b1;
          remaining <= RW'(CHAIN_LENGTH);
        end
        FETCH: if (bs_valid && bs_ready) begin
          state <= SHIFT;
          bs_ready <= 1'b0;
          ccff_shift_en <= 1'b1;
          ccff_head <= bs_data[0];
          sr <= bs_data >> 1;
          bit_cnt <= (int'(remaining) < WORD_WIDTH) ? CW'(remaining) : CW'(WORD_WIDTH);
        end
        SHIFT: begin
          remaining <= remaining - RW'(1);
          bit_cnt <= bit_cnt - CW'(1);
          sr <= sr >> 1;
          if (!last_bit) ccff_head <= sr[0];
          if (rb_full || last_chain) begin
            rb_data <= rb_next;
            rb_valid <= 1'b1;
            rb_buf <= '0;
            rb_idx <= '0;
          end else begin
            rb_buf <= rb_next;
            rb_idx <= rb_idx + CW'(1);
          end
          if (last_bit) begin
            ccff_shift_en <= 1'b0;
            state <= last_chain ? DONE : FETCH;
            done <= last_chain;
            bs_ready <= !last_chain;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table-driven and randomized loads of ccff_chain_loader checked against a bit-FIFO chain model
module tb_ccff_chain_loader;
  typedef struct {
    bit s;
    logic [7:0] w0, w1, w2;
    int gap;
    bit poke;
    logic [7:0] r0, r1, r2;
    int dcyc;
  } vec_t;
  logic prog_clk = 1'b0;
  logic pReset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, bs_valid = 1'b0;
  logic [7:0] bs_data = '0;
  logic rdy_a, head_a, sen_a, rbv_a, busy_a, done_a;
  logic rdy_b, head_b, sen_b, rbv_b, busy_b, done_b;
  logic [7:0] rb_a, rb_b;
  logic [19:0] chain_a = '0;
  logic [15:0] chain_b = '0;
  logic sel = 1'b0;
  logic rdy, head, sen, rbv, busy, done;
  logic [7:0] rb;
  bit fifo_a[$], fifo_b[$];
  int checks = 0, passes = 0;
  int obs_hs, obs_sh, obs_done, obs_rbn;
  logic [7:0] obs_rb[3], mdl_rb[3];
  logic [19:0] obs_heads, mdl_stream;
  bit hold_ok, busy_ok;
  logic busy_after, busy_after2, p_sen, p_rdy, p_busy, p_done, p_rbv;
  logic [7:0] p_rb;
  vec_t tbl[7];

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) begin
    if (sen_a) chain_a <= {chain_a[18:0], head_a};
    if (sen_b) chain_b <= {chain_b[14:0], head_b};
  end
  assign rdy = sel ? rdy_b : rdy_a;
  assign head = sel ? head_b : head_a;
  assign sen = sel ? sen_b : sen_a;
  assign rbv = sel ? rbv_b : rbv_a;
  assign busy = sel ? busy_b : busy_a;
  assign done = sel ? done_b : done_a;
  assign rb = sel ? rb_b : rb_a;

  ccff_chain_loader #(.CHAIN_LENGTH(20), .WORD_WIDTH(8)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .bs_data(bs_data), .bs_valid(bs_valid),
    .bs_ready(rdy_a), .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(chain_a[19]),
    .rb_data(rb_a), .rb_valid(rbv_a), .busy(busy_a), .done(done_a));
  ccff_chain_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .bs_data(bs_data), .bs_valid(bs_valid),
    .bs_ready(rdy_b), .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(chain_b[15]),
    .rb_data(rb_b), .rb_valid(rbv_b), .busy(busy_b), .done(done_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else start_a = v;
  endtask

  task automatic run_load(input bit s, input logic [7:0] w0, w1, w2, input int gap, input bit poke, input int rst_at);
    int cl, gap_left, wi;
    logic [7:0] w[3];
    logic last_head;
    bit t;
    cl = s ? 16 : 20;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    sel = s;
    obs_hs = 0;
    obs_sh = 0;
    obs_done = 0;
    obs_rbn = 0;
    obs_heads = '0;
    mdl_stream = '0;
    hold_ok = 1;
    busy_ok = 1;
    busy_after = 1'b1;
    busy_after2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      obs_rb[k] = '0;
      mdl_rb[k] = '0;
    end
    for (int b = 0; b < cl; b++) mdl_stream[b] = w[b / 8][b % 8];
    gap_left = 0;
    set_start(1'b1);
    bs_valid = 1'b1;
    bs_data = w0;
    @(posedge prog_clk); #1;
    set_start(1'b0);
    last_head = head;
    for (int cyc = 2; cyc < 400; cyc++) begin
      if (sen) begin
        if (obs_sh < cl) begin
          obs_heads[obs_sh] = head;
          if (s) begin
            t = fifo_b.pop_front();
            fifo_b.push_back(mdl_stream[obs_sh]);
          end else begin
            t = fifo_a.pop_front();
            fifo_a.push_back(mdl_stream[obs_sh]);
          end
          mdl_rb[obs_sh / 8][obs_sh % 8] = t;
        end
        obs_sh++;
      end else if (head !== last_head) hold_ok = 0;
      last_head = head;
      if (!busy) busy_ok = 0;
      if (rbv) begin
        if (obs_rbn < 3) obs_rb[obs_rbn] = rb;
        obs_rbn++;
      end
      if (rst_at != 0 && obs_sh == rst_at) begin
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        p_sen = sen;
        p_rdy = rdy;
        p_busy = busy;
        p_done = done;
        p_rbv = rbv;
        p_rb = rb;
        break;
      end
      if (done) begin
        obs_done = cyc;
        set_start(poke);
        bs_valid = 1'b0;
        @(posedge prog_clk); #1;
        set_start(1'b0);
        busy_after = busy;
        @(posedge prog_clk); #1;
        busy_after2 = busy;
        break;
      end
      set_start(poke && sen && obs_sh == 3);
      bs_valid = gap_left == 0;
      wi = obs_hs > 2 ? 2 : obs_hs;
      bs_data = w[wi];
      if (rdy && bs_valid) begin
        obs_hs++;
        gap_left = gap;
      end else if (rdy && gap_left > 0) gap_left--;
      @(posedge prog_clk); #1;
    end
    set_start(1'b0);
    bs_valid = 1'b0;
  endtask

  task automatic check_chain(input bit s);
    logic [19:0] e;
    e = '0;
    if (s) for (int k = 0; k < 16; k++) e[15-k] = fifo_b[k];
    else for (int k = 0; k < 20; k++) e[19-k] = fifo_a[k];
    check("chain_contents", s ? 32'(chain_b) : 32'(chain_a), 32'(e));
  endtask

  task automatic check_load(input bit s, input logic [7:0] r0, r1, r2, input int dcyc);
    int nw;
    logic [7:0] r[3];
    nw = s ? 2 : 3;
    r[0] = r0;
    r[1] = r1;
    r[2] = r2;
    check("handshakes", obs_hs, nw);
    check("shift_cycles", obs_sh, s ? 16 : 20);
    check("head_stream", 32'(obs_heads), 32'(mdl_stream));
    check("rb_count", obs_rbn, nw);
    for (int k = 0; k < nw; k++) check($sformatf("rb_word%0d", k), 32'(obs_rb[k]), 32'(r[k]));
    check("done_cycle", obs_done, dcyc);
    check("busy_during_load", 32'(busy_ok), 1);
    check("busy_after_done", 32'(busy_after), 0);
    check("no_restart", 32'(busy_after2), 0);
    check("head_hold", 32'(hold_ok), 1);
    check_chain(s);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 8'h3C, 8'hF7, 0, 1'b0, 8'h00, 8'h00, 8'h00, 25};
    tbl[1] = '{1'b0, 8'hA5, 8'h3C, 8'hF7, 0, 1'b0, 8'hA5, 8'h3C, 8'h07, 25};
    tbl[2] = '{1'b0, 8'hA5, 8'h3C, 8'hF7, 5, 1'b0, 8'hA5, 8'h3C, 8'h07, 35};
    tbl[3] = '{1'b0, 8'hA5, 8'h3C, 8'hF7, 0, 1'b1, 8'hA5, 8'h3C, 8'h07, 25};
    tbl[4] = '{1'b0, 8'h0F, 8'hF0, 8'h99, 0, 1'b0, 8'hE7, 8'h24, 8'h08, 25};
    tbl[5] = '{1'b1, 8'hC3, 8'h5A, 8'h00, 0, 1'b0, 8'h00, 8'h00, 8'h00, 20};
    tbl[6] = '{1'b1, 8'h81, 8'h7E, 8'h00, 0, 1'b0, 8'hC3, 8'h5A, 8'h00, 20};
    for (int k = 0; k < 20; k++) fifo_a.push_back(1'b0);
    for (int k = 0; k < 16; k++) fifo_b.push_back(1'b0);
    repeat (3) @(posedge prog_clk);
    #1;
    check("rst_bs_ready", 32'(rdy_a), 0);
    check("rst_head", 32'(head_a), 0);
    check("rst_shift_en", 32'(sen_a), 0);
    check("rst_rb_data", 32'(rb_a), 0);
    check("rst_rb_valid", 32'(rbv_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    pReset = 1'b0;
    @(posedge prog_clk); #1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        run_load(1'b0, 8'h12, 8'h34, 8'h56, 0, 1'b0, 11);
        check("rst_mid_shifts", obs_sh, 11);
        check("rst_mid_shift_en", 32'(p_sen), 0);
        check("rst_mid_bs_ready", 32'(p_rdy), 0);
        check("rst_mid_busy", 32'(p_busy), 0);
        check("rst_mid_done", 32'(p_done), 0);
        check("rst_mid_rb_valid", 32'(p_rbv), 0);
        check("rst_mid_rb_data", 32'(p_rb), 0);
        check("rst_mid_rb_count", obs_rbn, 1);
        check("rst_mid_rb0", 32'(obs_rb[0]), 32'h00A5);
        check_chain(1'b0);
      end
      run_load(tbl[i].s, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].gap, tbl[i].poke, 0);
      check_load(tbl[i].s, tbl[i].r0, tbl[i].r1, tbl[i].r2, tbl[i].dcyc);
    end
    for (int i = 0; i < 8; i++) begin
      bit rs;
      int rg, nw, cl;
      rs = $urandom_range(0, 1) == 1;
      rg = $urandom_range(0, 3);
      nw = rs ? 2 : 3;
      cl = rs ? 16 : 20;
      run_load(rs, 8'($urandom), 8'($urandom), 8'($urandom), rg, 1'b0, 0);
      check_load(rs, mdl_rb[0], mdl_rb[1], mdl_rb[2], nw + cl + 2 + rg * (nw - 1));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
